// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, one-hot FSM encoding, frame-length helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int ST_W = 5;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 5'b00001,
        ST_START = 5'b00010,
        ST_DATA  = 5'b00100,
        ST_PAR   = 5'b01000,
        ST_STOP  = 5'b10000
    } tx_state_e;

    // Bit periods per frame; the receiver uses the same count.
    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Fabric-side handshake and serial-side outputs of the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick;
    logic                 tx_start;
    logic [DATA_BITS-1:0] d_in;
    logic                 tx;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output baud_tick, tx_start, d_in,
        input  tx, tx_ready, tx_busy, tx_done
    );

    modport slave (
        input  baud_tick, tx_start, d_in,
        output tx, tx_ready, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Counts baud_tick pulses; bit_end flags the tick that completes an OVERSAMPLE-tick bit period.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_count,
    input  logic baud_tick,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);
    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_end = enable & baud_tick & (cnt_q == CW'(OVERSAMPLE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && baud_tick) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_count) begin
        if (!rst_count) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter: start, DATA_BITS LSB first, optional parity, STOP_BITS stops.
// One-word holding register lets the next frame follow the current one with no idle gap.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1
) (
    input logic          clk,
    input logic          rst_count,
    uart_tx_cfg_if.slave bus
);
    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_vld_q;
    logic                 par_q;
    logic [3:0]           bit_idx_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 done_q;

    logic [DATA_BITS-1:0] din;
    logic                 bit_end;
    logic                 accept;
    logic                 last_data;
    logic                 last_stop;
    logic                 frame_end;
    logic                 par_bit;
    logic                 in_idle;

    assign din       = bus.d_in;
    assign in_idle   = (state_q == ST_IDLE);
    assign accept    = bus.tx_start & ~hold_vld_q;
    assign last_data = (bit_idx_q == 4'(DATA_BITS - 1));
    assign last_stop = (bit_idx_q == 4'(STOP_BITS - 1));
    assign frame_end = (state_q == ST_STOP) & bit_end & last_stop;
    assign par_bit   = (PARITY == PAR_ODD) ? ~par_q : par_q;

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_timer (
        .clk       (clk),
        .rst_count (rst_count),
        .baud_tick (bus.baud_tick),
        .clear     (in_idle),
        .enable    (~in_idle),
        .bit_end   (bit_end)
    );

    always_ff @(posedge clk or negedge rst_count) begin
        if (!rst_count) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            par_q      <= 1'b0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Mid-frame acceptance parks the word; at frame end it is loaded directly instead.
            if (accept && !in_idle && !frame_end) begin
                hold_q     <= din;
                hold_vld_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shift_q   <= din;
                        par_q     <= ^din;
                        bit_idx_q <= '0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (last_data) begin
                            bit_idx_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= par_bit;
                                state_q <= ST_PAR;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                ST_PAR: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            done_q    <= 1'b1;
                            bit_idx_q <= '0;
                            if (hold_vld_q) begin
                                shift_q    <= hold_q;
                                par_q      <= ^hold_q;
                                hold_vld_q <= 1'b0;
                                tx_q       <= 1'b0;
                                state_q    <= ST_START;
                            end else if (bus.tx_start) begin
                                shift_q <= din;
                                par_q   <= ^din;
                                tx_q    <= 1'b0;
                                state_q <= ST_START;
                            end else begin
                                tx_q    <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = ~hold_vld_q;
    assign bus.tx_busy  = busy_q;
    assign bus.tx_done  = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations, tick-aligned monitor against a queue of expected line bits.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_count = 1'b0;
    logic       baud_tick = 1'b0;
    logic       start_drv = 1'b0;
    logic [8:0] d_drv = '0;
    int         sel = 0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_BITS(8)) if0 (), if1 (), if2 ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();

    assign if0.baud_tick = baud_tick;
    assign if1.baud_tick = baud_tick;
    assign if2.baud_tick = baud_tick;
    assign if3.baud_tick = baud_tick;
    assign if0.tx_start  = start_drv && (sel == 0);
    assign if1.tx_start  = start_drv && (sel == 1);
    assign if2.tx_start  = start_drv && (sel == 2);
    assign if3.tx_start  = start_drv && (sel == 3);
    assign if0.d_in      = d_drv[7:0];
    assign if1.d_in      = d_drv[7:0];
    assign if2.d_in      = d_drv[7:0];
    assign if3.d_in      = d_drv[6:0];

    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1))
        u0 (.clk(clk), .rst_count(rst_count), .bus(if0.slave));
    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1))
        u1 (.clk(clk), .rst_count(rst_count), .bus(if1.slave));
    uart_tx_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1))
        u2 (.clk(clk), .rst_count(rst_count), .bus(if2.slave));
    uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY(0), .STOP_BITS(2))
        u3 (.clk(clk), .rst_count(rst_count), .bus(if3.slave));

    logic tx_m, rdy_m, busy_m, done_m;
    always_comb begin
        case (sel)
            1:       {tx_m, rdy_m, busy_m, done_m} = {if1.tx, if1.tx_ready, if1.tx_busy, if1.tx_done};
            2:       {tx_m, rdy_m, busy_m, done_m} = {if2.tx, if2.tx_ready, if2.tx_busy, if2.tx_done};
            3:       {tx_m, rdy_m, busy_m, done_m} = {if3.tx, if3.tx_ready, if3.tx_busy, if3.tx_done};
            default: {tx_m, rdy_m, busy_m, done_m} = {if0.tx, if0.tx_ready, if0.tx_busy, if0.tx_done};
        endcase
    end

    function automatic int cfg_os(input int s);   return (s == 3) ? 8 : 16; endfunction
    function automatic int cfg_db(input int s);   return (s == 3) ? 7 : 8; endfunction
    function automatic int cfg_par(input int s);  return (s == 1) ? 1 : ((s == 2) ? 2 : 0); endfunction
    function automatic int cfg_stop(input int s); return (s == 3) ? 2 : 1; endfunction

    typedef struct packed {
        logic b;
        logic last;
    } ebit_t;

    ebit_t sb[$];

    function automatic ebit_t mk(input logic b, input logic last);
        ebit_t e;
        e.b    = b;
        e.last = last;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [8:0] w);
        logic p;
        p = 1'b0;
        sb.push_back(mk(1'b0, 1'b0));
        for (int i = 0; i < cfg_db(sel); i++) begin
            sb.push_back(mk(w[i], 1'b0));
            p = p ^ w[i];
        end
        if (cfg_par(sel) != 0)
            sb.push_back(mk((cfg_par(sel) == 2) ? ~p : p, 1'b0));
        for (int i = 0; i < cfg_stop(sel); i++)
            sb.push_back(mk(1'b1, i == cfg_stop(sel) - 1));
    endtask

    // Monitor and tick source: samples one bit period per OVERSAMPLE ticks of the selected DUT.
    int   tcnt = 0;
    int   tick_div = 0;
    logic busy_prev = 1'b0;
    logic eof_next = 1'b0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (!rst_count) begin
            tcnt      = 0;
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && baud_tick) begin
                tcnt++;
                if (sb.size() == 0) begin
                    if (tcnt == 1) chk("no_frame_expected", busy_prev, 1'b0);
                    if (tcnt == cfg_os(sel)) tcnt = 0;
                end else begin
                    if (tcnt == cfg_os(sel) / 2) chk("tx_mid_bit", tx_m, sb[0].b);
                    if (tcnt == cfg_os(sel) - 1) chk("tx_end_bit", tx_m, sb[0].b);
                    if (tcnt == cfg_os(sel)) begin
                        chk("tx_done_at_bit_end", done_m, sb[0].last);
                        void'(sb.pop_front());
                        tcnt = 0;
                    end
                end
            end
            busy_prev = busy_m;
            if (done_m) done_cnt++;
        end
        tick_div  = (tick_div + 1) % 2;
        baud_tick = (tick_div == 0);
        eof_next  = baud_tick && busy_prev && (sb.size() == 1) && (tcnt == cfg_os(sel) - 1);
    end

    task automatic send(input logic [8:0] w);
        @(negedge clk);
        d_drv     = w;
        start_drv = 1'b1;
        if (rdy_m) push_frame(w);
        @(negedge clk);
        start_drv = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((busy_m || sb.size() != 0) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk("idle_reached", {31'd0, (busy_m == 1'b0) && (sb.size() == 0)}, 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d0;
        int  i;
        logic found;

        repeat (3) @(negedge clk);
        chk("reset_tx", tx_m, 1'b1);
        chk("reset_ready", rdy_m, 1'b1);
        chk("reset_busy", busy_m, 1'b0);
        chk("reset_done", done_m, 1'b0);
        chk("reset_tx_cfg3", if3.tx, 1'b1);
        rst_count = 1'b1;
        repeat (4) @(negedge clk);

        // Default frame: A5 -> 0,1,0,1,0,0,1,0,1,1
        sel = 0; d0 = done_cnt;
        send(9'h0A5);
        chk("start_bit_latency", tx_m, 1'b0);
        chk("busy_rise", busy_m, 1'b1);
        wait_idle();
        chk("done_once_a5", done_cnt - d0, 1);

        sel = 1; d0 = done_cnt;
        send(9'h007);
        wait_idle();
        chk("done_even_par", done_cnt - d0, 1);

        sel = 2; d0 = done_cnt;
        send(9'h007);
        wait_idle();
        chk("done_odd_par", done_cnt - d0, 1);

        sel = 3; d0 = done_cnt;
        send(9'h055);
        wait_idle();
        chk("done_7b_2stop", done_cnt - d0, 1);

        // Holding register: queued word follows with no gap, third start ignored
        sel = 0; d0 = done_cnt;
        send(9'h011);
        repeat (60) @(negedge clk);
        send(9'h022);
        chk("ready_drops", rdy_m, 1'b0);
        send(9'h033);
        chk("ready_still_low", rdy_m, 1'b0);
        found = 1'b0;
        i = 0;
        while (!found && i < 1000) begin
            @(negedge clk);
            if (done_m) found = 1'b1;
            i++;
        end
        chk("first_done_seen", found, 1'b1);
        chk("b2b_busy_held", busy_m, 1'b1);
        chk("ready_rises_on_move", rdy_m, 1'b1);
        chk("b2b_start_bit", tx_m, 1'b0);
        wait_idle();
        chk("done_twice", done_cnt - d0, 2);
        repeat (100) @(negedge clk);
        chk("no_third_frame", busy_m, 1'b0);

        // Reset mid-frame aborts silently
        sel = 0; d0 = done_cnt;
        send(9'h000);
        repeat (150) @(negedge clk);
        chk("pre_reset_tx_low", tx_m, 1'b0);
        rst_count = 1'b0;
        sb.delete();
        #1;
        chk("abort_tx_high", tx_m, 1'b1);
        chk("abort_busy", busy_m, 1'b0);
        chk("abort_ready", rdy_m, 1'b1);
        chk("abort_done", done_m, 1'b0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        rst_count = 1'b1;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        send(9'h03C);
        wait_idle();
        chk("clean_after_reset", done_cnt - d0, 1);

        // Start coincident with end of frame, holding register empty
        sel = 0; d0 = done_cnt;
        send(9'h05A);
        found = 1'b0;
        i = 0;
        while (!found && i < 2000) begin
            @(negedge clk);
            #1;
            if (eof_next) found = 1'b1;
            i++;
        end
        chk("eof_found", found, 1'b1);
        if (found) begin
            start_drv = 1'b1;
            d_drv     = 9'h0C3;
            chk("coincident_ready", rdy_m, 1'b1);
            push_frame(9'h0C3);
            @(negedge clk);
            start_drv = 1'b0;
            chk("coincident_done", done_m, 1'b1);
            chk("coincident_busy", busy_m, 1'b1);
            chk("coincident_ready_kept", rdy_m, 1'b1);
            chk("coincident_start_bit", tx_m, 1'b0);
        end
        wait_idle();
        chk("coincident_done_twice", done_cnt - d0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
